// File: rtl/rega_pkg.sv
// rega_pkg: shared definitions for the irrigation sequencer.
//   - state_e   : 3-bit state encoding (also driven out on the State port)
//   - LVL_MAX / LVL_LOW : valve levels for a full and a half-full tank
//   - DRY_TH_DEF / WET_TH_DEF : default humidity thresholds
//   - target_level() : target valve level for the current tank condition
package rega_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RAMP_UP   = 3'd1,
      S_WATER     = 3'd2,
      S_RAMP_DOWN = 3'd3,
      S_COOLDOWN  = 3'd4,
      S_FAULT     = 3'd5
   } state_e;

   localparam logic [1:0] LVL_MAX    = 2'd3;
   localparam logic [1:0] LVL_LOW    = 2'd2;
   localparam logic [1:0] DRY_TH_DEF = 2'd1;
   localparam logic [1:0] WET_TH_DEF = 2'd3;

   // A half-empty tank caps the valve one step below full.
   function automatic logic [1:0] target_level(input logic tank_low);
      return tank_low ? LVL_LOW : LVL_MAX;
   endfunction

endpackage

// File: rtl/rega_if.sv
// rega_if: sensor / counter / status bundle of the irrigation sequencer.
//   Inputs to the controller : Hum, Start, Tank_low, Tank_empty, Ack, Q
//   Outputs of the controller: Cnt_en, Cnt_up, Pump, Alarm, State, Done_cnt
// Signalling is level-based: every input is sampled on each rising clock
// edge and there is no valid/ready handshake; Cnt_en/Cnt_up are
// combinational so the external counter steps on the same edge that the
// controller observes the current Q.
// modport slave  : the controller (rega_ctrl)
// modport master : the environment (sensor front-end + valve-level counter)
interface rega_if;
   logic [1:0] Hum;
   logic       Start;
   logic       Tank_low;
   logic       Tank_empty;
   logic       Ack;
   logic [1:0] Q;
   logic       Cnt_en;
   logic       Cnt_up;
   logic       Pump;
   logic       Alarm;
   logic [2:0] State;
   logic [7:0] Done_cnt;

   modport slave (
      input  Hum, Start, Tank_low, Tank_empty, Ack, Q,
      output Cnt_en, Cnt_up, Pump, Alarm, State, Done_cnt
   );

   modport master (
      output Hum, Start, Tank_low, Tank_empty, Ack, Q,
      input  Cnt_en, Cnt_up, Pump, Alarm, State, Done_cnt
   );
endinterface

// File: rtl/rega_timer.sv
// rega_timer: TW-bit loadable down-counter used for WATER and COOLDOWN.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (wins over dec)
//   load_val   : value to load
//   dec        : decrement by one; holds at zero
//   count      : current value
//   zero       : count == 0
module rega_timer #(
   parameter int TW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   input  logic          dec,
   output logic [TW-1:0] count,
   output logic          zero
);

   logic [TW-1:0] count_q;
   logic [TW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/rega_ctrl.sv
// rega_ctrl: irrigation sequencer driving a 2-bit up/down valve-level counter.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   bus        : rega_if.slave
//     Hum, Start, Tank_low, Tank_empty, Ack : sensor / operator inputs
//     Q                                     : counter feedback
//     Cnt_en, Cnt_up : counter step enable / direction (combinational)
//     Pump, Alarm    : registered, one clock behind the state
//     State          : current state code
//     Done_cnt       : completed waterings, saturating at 255
module rega_ctrl
   import rega_pkg::*;
#(
   parameter int         TW           = 8,
   parameter int         WATER_CYCLES = 16,
   parameter int         COOL_CYCLES  = 8,
   parameter logic [1:0] DRY_TH       = DRY_TH_DEF,
   parameter logic [1:0] WET_TH       = WET_TH_DEF
) (
   input  logic  Clk,
   input  logic  Rst_n,
   rega_if.slave bus
);

   localparam logic [TW-1:0] WATER_TR = TW'(WATER_CYCLES);
   localparam logic [TW-1:0] COOL_TR  = TW'(COOL_CYCLES);
   localparam logic [TW-1:0] WATER_LD = WATER_TR - TW'(1);
   localparam logic [TW-1:0] COOL_LD  = COOL_TR - TW'(1);

   if (WATER_TR == '0) begin : g_bad_water
      $error("rega_ctrl: WATER_CYCLES truncates to zero");
   end
   if (COOL_TR == '0) begin : g_bad_cool
      $error("rega_ctrl: COOL_CYCLES truncates to zero");
   end

   state_e     state_q, state_d;
   logic       fault_q, fault_d;
   logic [7:0] done_q, done_d;
   logic       pump_q, pump_d;
   logic       alarm_q, alarm_d;

   logic [1:0]    target;
   logic          tmr_load;
   logic [TW-1:0] tmr_val;
   logic          tmr_dec;
   logic          tmr_zero;
   logic [TW-1:0] tmr_count;
   logic          cnt_en;
   logic          cnt_up;

   assign target = target_level(bus.Tank_low);

   rega_timer #(.TW(TW)) u_timer (
      .clk      (Clk),
      .rst_n    (Rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .count    (tmr_count),
      .zero     (tmr_zero)
   );

   // Next state, fault flag, timer control and completion count.
   always_comb begin
      state_d  = state_q;
      fault_d  = fault_q;
      done_d   = done_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      tmr_dec  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.Tank_empty) begin
               state_d = S_FAULT;
               fault_d = 1'b1;
            end else if ((bus.Hum <= DRY_TH) || bus.Start) begin
               state_d = S_RAMP_UP;
            end
         end
         S_RAMP_UP: begin
            if (bus.Tank_empty) begin
               state_d = S_RAMP_DOWN;
               fault_d = 1'b1;
            end else if (bus.Q == target) begin
               state_d  = S_WATER;
               tmr_load = 1'b1;
               tmr_val  = WATER_LD;
            end else if (bus.Q > target) begin
               // Tank_low rose after the valve already passed the new target.
               state_d = S_RAMP_DOWN;
               fault_d = 1'b0;
            end
         end
         S_WATER: begin
            tmr_dec = 1'b1;
            if (bus.Tank_empty) begin
               state_d = S_RAMP_DOWN;
               fault_d = 1'b1;
            end else if (tmr_zero || (bus.Hum >= WET_TH)) begin
               state_d = S_RAMP_DOWN;
            end
         end
         S_RAMP_DOWN: begin
            if (bus.Q == 2'd0) begin
               if (fault_q) begin
                  state_d = S_FAULT;
               end else begin
                  state_d  = S_COOLDOWN;
                  tmr_load = 1'b1;
                  tmr_val  = COOL_LD;
                  if (done_q != 8'hFF) begin
                     done_d = done_q + 8'd1;
                  end
               end
            end
         end
         S_COOLDOWN: begin
            tmr_dec = 1'b1;
            if (bus.Tank_empty) begin
               state_d = S_FAULT;
               fault_d = 1'b1;
            end else if (tmr_zero) begin
               state_d = S_IDLE;
            end
         end
         S_FAULT: begin
            if (bus.Ack && !bus.Tank_empty && (bus.Q == 2'd0)) begin
               state_d = S_IDLE;
               fault_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      pump_d  = (state_q == S_WATER);
      alarm_d = (state_q == S_FAULT);
   end

   // Counter commands. Up-steps only while below target and down-steps only
   // while above zero (or above target in WATER), so a wrap is never issued.
   always_comb begin
      cnt_en = 1'b0;
      cnt_up = 1'b0;
      case (state_q)
         S_RAMP_UP: begin
            cnt_en = (bus.Q < target) && !bus.Tank_empty;
            cnt_up = cnt_en;
         end
         S_WATER:     cnt_en = (bus.Q > target);
         S_RAMP_DOWN: cnt_en = (bus.Q != 2'd0);
         S_FAULT:     cnt_en = (bus.Q != 2'd0);
         default: begin
            cnt_en = 1'b0;
            cnt_up = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= S_IDLE;
         fault_q <= 1'b0;
         done_q  <= 8'd0;
         pump_q  <= 1'b0;
         alarm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
         done_q  <= done_d;
         pump_q  <= pump_d;
         alarm_q <= alarm_d;
      end
   end

   assign bus.Cnt_en   = cnt_en;
   assign bus.Cnt_up   = cnt_up;
   assign bus.Pump     = pump_q;
   assign bus.Alarm    = alarm_q;
   assign bus.State    = state_q;
   assign bus.Done_cnt = done_q;

endmodule

// File: tb/tb_rega_ctrl.sv
// tb_rega_ctrl: directed bench for rega_ctrl with a behavioural 2-bit
// up/down counter closing the Q feedback loop. A second instance with
// one-cycle WATER/COOLDOWN exercises Done_cnt saturation.
module tb_rega_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst2_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   rega_if intf();
   rega_if intf2();

   logic [1:0] q_m  = 2'd0;
   logic [1:0] q2_m = 2'd0;

   // External valve-level counters (no reset: the level survives a controller reset).
   always @(posedge clk) begin
      if (intf.Cnt_en) q_m <= intf.Cnt_up ? q_m + 2'd1 : q_m - 2'd1;
      if (intf2.Cnt_en) q2_m <= intf2.Cnt_up ? q2_m + 2'd1 : q2_m - 2'd1;
   end
   assign intf.Q  = q_m;
   assign intf2.Q = q2_m;

   rega_ctrl u_dut (
      .Clk   (clk),
      .Rst_n (rst_n),
      .bus   (intf)
   );

   rega_ctrl #(.WATER_CYCLES(1), .COOL_CYCLES(1)) u_sat (
      .Clk   (clk),
      .Rst_n (rst2_n),
      .bus   (intf2)
   );

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget);
      int n = 0;
      while (intf.State !== s && n < budget) begin
         tick();
         n++;
      end
      chk("wait_state", {29'd0, intf.State}, {29'd0, s});
   endtask

   initial begin
      int n;
      intf.Hum = 2'd3; intf.Start = 0; intf.Tank_low = 0; intf.Tank_empty = 0; intf.Ack = 0;
      intf2.Hum = 2'd0; intf2.Start = 0; intf2.Tank_low = 0; intf2.Tank_empty = 0; intf2.Ack = 0;
      #1;
      chk("rst_state", intf.State, 0);
      chk("rst_pump", intf.Pump, 0);
      chk("rst_alarm", intf.Alarm, 0);
      chk("rst_cnt_en", intf.Cnt_en, 0);
      chk("rst_cnt_up", intf.Cnt_up, 0);
      chk("rst_done", intf.Done_cnt, 0);
      @(negedge clk) rst_n = 1'b1;
      tick(2);
      chk("idle_wet", intf.State, 0);

      // Dry cycle
      intf.Hum = 2'd0;
      tick();
      chk("dry_ramp_state", intf.State, 1);
      chk("dry_ramp_en", intf.Cnt_en, 1);
      chk("dry_ramp_up", intf.Cnt_up, 1);
      intf.Hum = 2'd2;
      tick(); chk("dry_q1", q_m, 1);
      tick(); chk("dry_q2", q_m, 2);
      tick(); chk("dry_q3", q_m, 3);
      chk("dry_en_at_target", intf.Cnt_en, 0);
      tick();
      chk("dry_water", intf.State, 2);
      chk("dry_pump_lag", intf.Pump, 0);
      tick();
      n = 0;
      while (intf.Pump === 1'b1 && n < 40) begin n++; tick(); end
      chk("dry_pump_cycles", n, 16);
      chk("dry_rd_state", intf.State, 3);
      chk("dry_rd_q2", q_m, 2);
      tick(); chk("dry_rd_q1", q_m, 1);
      tick(); chk("dry_rd_q0", q_m, 0);
      tick();
      chk("dry_cool", intf.State, 4);
      chk("dry_done", intf.Done_cnt, 1);
      n = 0;
      while (intf.State === 3'd4 && n < 40) begin n++; tick(); end
      chk("dry_cool_cycles", n, 8);
      chk("dry_idle", intf.State, 0);

      // Early wet stop at timer=10
      intf.Start = 1;
      tick(); chk("wet_ramp", intf.State, 1);
      intf.Start = 0;
      tick(3); chk("wet_q3", q_m, 3);
      tick(); chk("wet_water", intf.State, 2);
      tick(5);
      intf.Hum = 2'd3;
      tick();
      chk("wet_stop_state", intf.State, 3);
      chk("wet_stop_pump", intf.Pump, 1);
      intf.Hum = 2'd2;
      tick();
      chk("wet_pump_off", intf.Pump, 0);
      chk("wet_q2", q_m, 2);
      wait_state(3'd4, 10);
      chk("wet_done", intf.Done_cnt, 2);
      wait_state(3'd0, 20);

      // Tank_low caps the ramp at 2
      intf.Tank_low = 1; intf.Start = 1;
      tick(); chk("low_ramp", intf.State, 1);
      intf.Start = 0;
      tick(2);
      chk("low_q2", q_m, 2);
      chk("low_en_off", intf.Cnt_en, 0);
      tick();
      chk("low_water", intf.State, 2);
      chk("low_q_hold", q_m, 2);
      intf.Hum = 2'd3;
      tick(); chk("low_rd", intf.State, 3);
      intf.Hum = 2'd2; intf.Tank_low = 0;
      wait_state(3'd4, 10);
      chk("low_done", intf.Done_cnt, 3);
      wait_state(3'd0, 20);

      // Tank_low rising while Q=3 in WATER
      intf.Start = 1;
      tick(); intf.Start = 0;
      wait_state(3'd2, 10);
      chk("step_q3", q_m, 3);
      tick();
      chk("step_pump", intf.Pump, 1);
      intf.Tank_low = 1;
      #1;
      chk("step_en", intf.Cnt_en, 1);
      chk("step_dir", intf.Cnt_up, 0);
      tick();
      chk("step_q2", q_m, 2);
      chk("step_en_off", intf.Cnt_en, 0);
      chk("step_state", intf.State, 2);
      chk("step_pump2", intf.Pump, 1);
      tick();
      chk("step_q2_hold", q_m, 2);
      intf.Tank_low = 0; intf.Hum = 2'd3;
      tick(); chk("step_rd", intf.State, 3);
      intf.Hum = 2'd2;
      wait_state(3'd0, 40);
      chk("step_done", intf.Done_cnt, 4);

      // Tank empty mid-water
      intf.Start = 1;
      tick(); intf.Start = 0;
      wait_state(3'd2, 10);
      tick(2);
      intf.Tank_empty = 1;
      tick();
      chk("empty_rd", intf.State, 3);
      wait_state(3'd5, 10);
      chk("empty_q0", q_m, 0);
      chk("empty_done", intf.Done_cnt, 4);
      chk("empty_alarm_lag", intf.Alarm, 0);
      tick();
      chk("empty_alarm", intf.Alarm, 1);
      chk("empty_pump", intf.Pump, 0);
      intf.Ack = 1;
      tick();
      chk("empty_ack_ignored", intf.State, 5);
      intf.Tank_empty = 0;
      tick();
      chk("empty_exit", intf.State, 0);
      chk("empty_alarm_hold", intf.Alarm, 1);
      tick();
      chk("empty_alarm_off", intf.Alarm, 0);
      intf.Ack = 0;

      // Async reset mid-ramp at Q=2
      intf.Start = 1;
      tick(); intf.Start = 0;
      tick(2);
      chk("ar_q2", q_m, 2);
      chk("ar_state_pre", intf.State, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_state", intf.State, 0);
      chk("ar_pump", intf.Pump, 0);
      chk("ar_done", intf.Done_cnt, 0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      chk("ar_q_kept", q_m, 2);
      intf.Start = 1;
      tick();
      chk("ar_ramp", intf.State, 1);
      chk("ar_en_up", intf.Cnt_up, 1);
      intf.Start = 0;
      tick(); chk("ar_q3", q_m, 3);
      tick(); chk("ar_water", intf.State, 2);
      tick(); chk("ar_pump_on", intf.Pump, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar2_pump", intf.Pump, 0);
      chk("ar2_state", intf.State, 0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Tank empty in IDLE beats Start; stale Q ramps down inside FAULT
      intf.Tank_empty = 1; intf.Start = 1;
      tick();
      chk("idle_fault", intf.State, 5);
      chk("fault_en", intf.Cnt_en, 1);
      chk("fault_dir", intf.Cnt_up, 0);
      intf.Start = 0;
      tick(3);
      chk("fault_q0", q_m, 0);
      chk("fault_en_off", intf.Cnt_en, 0);
      chk("fault_alarm", intf.Alarm, 1);
      intf.Ack = 1;
      tick(); chk("fault_ack_ignored", intf.State, 5);
      intf.Tank_empty = 0;
      tick(); chk("fault_exit", intf.State, 0);
      intf.Ack = 0;
      chk("fault_done", intf.Done_cnt, 0);

      // Done_cnt saturation on the short-cycle instance
      @(negedge clk) rst2_n = 1'b1;
      n = 0;
      while (intf2.Done_cnt !== 8'd255 && n < 6000) begin n++; tick(); end
      chk("sat_reach", intf2.Done_cnt, 255);
      tick(40);
      chk("sat_hold", intf2.Done_cnt, 255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
